// File: rtl/mandel_scan_pkg.sv
// Shared definitions for the Mandelbrot pixel scan path: the scan state
// encoding, the default raster resolution and the double bit-pattern type
// used between the sequencer and the coordinate scalers.
package mandel_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_t;

  localparam int H_RES_DEFAULT = 640;
  localparam int V_RES_DEFAULT = 480;

  // IEEE-754 double carried as a raw bit pattern; no arithmetic happens here
  typedef logic [63:0] double_t;

endpackage

// File: rtl/scan_axis_counter.sv
// One raster axis counter. It counts 0..limit, wrapping back to 0 when it
// steps while already at the limit. at_limit is combinational, so the
// neighbouring axis and the flag outputs see it with no extra latency.
module scan_axis_counter #(
  parameter int IDX_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step,
  input  logic             clear,
  input  logic [IDX_W-1:0] limit,
  output logic [IDX_W-1:0] count,
  output logic             at_limit
);

  assign at_limit = (count == limit);

  // Count register: clear wins over step, and wrap replaces increment at the limit
  always_ff @(posedge clock) begin
    if (reset || clear)
      count <= '0;
    else if (step)
      count <= at_limit ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/pixel_scan_sequencer.sv
// Raster pixel index generator for the Mandelbrot viewer. It emits one
// (x, y) index per valid/ready transfer and holds a viewport snapshot that
// is taken when the frame starts, so the scalers work on a stable range.
// Optional build macro PIXEL_SCAN_CONTINUOUS_EN: frames repeat back to back
// after a single start, re-latching the viewport at each frame boundary.
module pixel_scan_sequencer
  import mandel_scan_pkg::*;
#(
  parameter int H_RES = H_RES_DEFAULT,
  parameter int V_RES = V_RES_DEFAULT,
  parameter int IDX_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [63:0]       cfg_x_offset,
  input  logic [63:0]       cfg_x_width,
  input  logic [63:0]       cfg_y_offset,
  input  logic [63:0]       cfg_y_width,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  x_idx,
  output logic [IDX_W-1:0]  y_idx,
  output logic [63:0]       x_offset,
  output logic [63:0]       x_width,
  output logic [63:0]       y_offset,
  output logic [63:0]       y_width,
  output logic              last_in_row,
  output logic              last_in_frame,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [IDX_W-1:0] X_LIM = IDX_W'(H_RES - 1);
  localparam logic [IDX_W-1:0] Y_LIM = IDX_W'(V_RES - 1);

  scan_state_t state;

  logic    transfer;
  logic    x_wrap;
  logic    y_at_lim;
  logic    final_px;
  logic    x_step;
  logic    y_step;
  logic    clear_cnt;
  logic    frame_start;
  double_t vp_x_off, vp_x_wid, vp_y_off, vp_y_wid;

  assign transfer = out_valid & out_ready;
  assign final_px = x_wrap & y_at_lim;

  // Flags derive from the registered counters; gating with out_valid keeps
  // them low in IDLE/DONE even though x/y still hold the final pixel there.
  assign last_in_row   = out_valid & x_wrap;
  assign last_in_frame = out_valid & final_px;

  // The final pixel does not step either axis, so x/y hold (H_RES-1, V_RES-1)
  assign x_step = transfer & ~final_px;
  assign y_step = transfer & x_wrap & ~y_at_lim;

`ifdef PIXEL_SCAN_CONTINUOUS_EN
  assign frame_start = (state == ST_IDLE && start) || (state == ST_DONE);
`else
  assign frame_start = (state == ST_IDLE && start);
`endif
  assign clear_cnt = frame_start;

  scan_axis_counter #(.IDX_W(IDX_W)) u_x_cnt (
    .clock    (clock),
    .reset    (reset),
    .step     (x_step),
    .clear    (clear_cnt),
    .limit    (X_LIM),
    .count    (x_idx),
    .at_limit (x_wrap)
  );

  scan_axis_counter #(.IDX_W(IDX_W)) u_y_cnt (
    .clock    (clock),
    .reset    (reset),
    .step     (y_step),
    .clear    (clear_cnt),
    .limit    (Y_LIM),
    .count    (y_idx),
    .at_limit (y_at_lim)
  );

  assign x_offset = vp_x_off;
  assign x_width  = vp_x_wid;
  assign y_offset = vp_y_off;
  assign y_width  = vp_y_wid;

  // Viewport snapshot: only updated at a frame start, stable for the whole frame
  always_ff @(posedge clock) begin
    if (reset) begin
      vp_x_off <= '0;
      vp_x_wid <= '0;
      vp_y_off <= '0;
      vp_y_wid <= '0;
    end else if (frame_start) begin
      vp_x_off <= cfg_x_offset;
      vp_x_wid <= cfg_x_width;
      vp_y_off <= cfg_y_offset;
      vp_y_wid <= cfg_y_width;
    end
  end

  // Frame FSM with registered valid/busy/done; start is only looked at in IDLE
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          frame_done <= 1'b0;
          if (start) begin
            state     <= ST_SCAN;
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (transfer && final_px) begin
            state      <= ST_DONE;
            out_valid  <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        ST_DONE: begin
          frame_done <= 1'b0;
`ifdef PIXEL_SCAN_CONTINUOUS_EN
          state      <= ST_SCAN;
          out_valid  <= 1'b1;
`else
          state      <= ST_IDLE;
          busy       <= 1'b0;
`endif
        end
        default: begin
          state      <= ST_IDLE;
          out_valid  <= 1'b0;
          busy       <= 1'b0;
          frame_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_scan_sequencer.sv
// Randomized bench for pixel_scan_sequencer on a 4x3 raster. The reference
// is a pixel number n: the expected index is (n mod H, n div H), and the
// expected viewport is whatever cfg was presented when the frame started.
module tb_pixel_scan_sequencer;

  localparam int H = 4;
  localparam int V = 3;
  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [63:0]   cfg_x_offset, cfg_x_width, cfg_y_offset, cfg_y_width;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  x_idx, y_idx;
  logic [63:0]   x_offset, x_width, y_offset, y_width;
  logic          last_in_row, last_in_frame, busy, frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  pixel_scan_sequencer #(.H_RES(H), .V_RES(V), .IDX_W(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .cfg_x_offset  (cfg_x_offset),
    .cfg_x_width   (cfg_x_width),
    .cfg_y_offset  (cfg_y_offset),
    .cfg_y_width   (cfg_y_width),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .x_idx         (x_idx),
    .y_idx         (y_idx),
    .x_offset      (x_offset),
    .x_width       (x_width),
    .y_offset      (y_offset),
    .y_width       (y_width),
    .last_in_row   (last_in_row),
    .last_in_frame (last_in_frame),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s got %h want %h", tag, obs, exp);
  endtask

  task automatic rand_cfg();
    cfg_x_offset = ($urandom_range(1, 0) == 1) ? 64'hBFF0000000000000 : {$urandom, $urandom};
    cfg_x_width  = {$urandom, $urandom};
    cfg_y_offset = {$urandom, $urandom};
    cfg_y_width  = {$urandom, $urandom};
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_done"},  64'(frame_done), 64'd0);
    chk({tag, "_lir"},   64'(last_in_row), 64'd0);
    chk({tag, "_lif"},   64'(last_in_frame), 64'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_idle(tag);
    chk({tag, "_x"},    64'(x_idx), 64'd0);
    chk({tag, "_y"},    64'(y_idx), 64'd0);
    chk({tag, "_xoff"}, x_offset, 64'd0);
    chk({tag, "_xwid"}, x_width, 64'd0);
    chk({tag, "_yoff"}, y_offset, 64'd0);
    chk({tag, "_ywid"}, y_width, 64'd0);
  endtask

  // mode 0: ready always high; mode 1: random ready plus a 5-cycle stall at (2,1).
  // abort_at >= 0 pulls reset while pixel abort_at is on the output.
  task automatic run_frame(input int mode, input int abort_at);
    logic [63:0] e_xo, e_xw, e_yo, e_yw;
    int n, stall, guard;
    logic rdy;
    // called at a negedge with the DUT in IDLE
    rand_cfg();
    if (mode == 0) cfg_x_offset = 64'h4000000000000000;
    e_xo = cfg_x_offset; e_xw = cfg_x_width; e_yo = cfg_y_offset; e_yw = cfg_y_width;
    start = 1'b1;
    out_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    n = 0; stall = 0; guard = 0;
    while (n < H * V) begin
      chk("valid", 64'(out_valid), 64'd1);
      chk("busy",  64'(busy), 64'd1);
      chk("fdone", 64'(frame_done), 64'd0);
      chk("x",     64'(x_idx), 64'(n % H));
      chk("y",     64'(y_idx), 64'(n / H));
      chk("lir",   64'(last_in_row), 64'((n % H) == H - 1));
      chk("lif",   64'(last_in_frame), 64'(n == H * V - 1));
      chk("xoff",  x_offset, e_xo);
      chk("xwid",  x_width, e_xw);
      chk("yoff",  y_offset, e_yo);
      chk("ywid",  y_width, e_yw);
      if (n == abort_at) begin
        reset = 1'b1;
        @(negedge clock);
        chk_reset_vals("abort");
        reset = 1'b0;
        @(negedge clock);
        chk_idle("post_abort");
        return;
      end
      rand_cfg();
      start = ($urandom_range(3, 0) == 0);
      if (mode == 0) rdy = 1'b1;
      else if (n == 6 && stall < 5) begin rdy = 1'b0; stall++; end
      else rdy = 1'($urandom_range(1, 0));
      out_ready = rdy;
      if (rdy) n++;
      @(negedge clock);
      guard++;
      if (guard > 2000) begin
        chk("frame_timeout", 64'(n), 64'(H * V));
        break;
      end
    end
    // DONE cycle
    out_ready = 1'($urandom_range(1, 0));
    chk("done_valid", 64'(out_valid), 64'd0);
    chk("done_pulse", 64'(frame_done), 64'd1);
    chk("done_busy",  64'(busy), 64'd1);
    chk("done_lif",   64'(last_in_frame), 64'd0);
    chk("done_x",     64'(x_idx), 64'(H - 1));
    chk("done_y",     64'(y_idx), 64'(V - 1));
    rand_cfg();
    e_xo = cfg_x_offset; e_xw = cfg_x_width;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
`ifdef PIXEL_SCAN_CONTINUOUS_EN
    chk("cont_valid", 64'(out_valid), 64'd1);
    chk("cont_busy",  64'(busy), 64'd1);
    chk("cont_done",  64'(frame_done), 64'd0);
    chk("cont_x",     64'(x_idx), 64'd0);
    chk("cont_y",     64'(y_idx), 64'd0);
    chk("cont_xoff",  x_offset, e_xo);
    chk("cont_xwid",  x_width, e_xw);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
`else
    chk_idle("after_done");
    @(negedge clock);
    chk_idle("start_in_done_ignored");
`endif
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    cfg_x_offset = '0; cfg_x_width = '0; cfg_y_offset = '0; cfg_y_width = '0;
    repeat (3) @(negedge clock);
    chk_reset_vals("reset");
    // reset must beat start in the same cycle
    start = 1'b1;
    rand_cfg();
    @(negedge clock);
    chk_reset_vals("reset_vs_start");
    reset = 1'b0;
    start = 1'b0;
    @(negedge clock);
    chk_idle("idle");

    run_frame(0, -1);
    run_frame(1, -1);
    run_frame(1, 5);
    run_frame(1, -1);
    for (int i = 0; i < 4; i++) run_frame(int'($urandom_range(1, 0)), -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pixel_scan_sequencer.md
# pixel_scan_sequencer

Generates the raster sequence of pixel indices (x, y) that drives the per-axis linear scalers of the Mandelbrot viewer, one pixel per valid/ready transfer. It latches the viewport (offset/width per axis, IEEE-754 double bit patterns) at frame start so the scalers see a stable range for the whole frame. It sits between the viewport control logic and the coordinate scalers feeding the iteration engines.

## Interface
- H_RES, 640, pixels per row (≥2)
- V_RES, 480, rows per frame (≥2)
- IDX_W, 32, width of x_idx/y_idx (must hold H_RES-1 and V_RES-1)
- clock  in  1  rising-edge clock; one clock domain
- reset  in  1  synchronous, active-high reset
- start  in  1  request a frame; sampled only in IDLE
- cfg_x_offset, cfg_x_width, cfg_y_offset, cfg_y_width  in  64 each  viewport, double bit patterns
- out_valid  out  1  pixel index available
- out_ready  in  1  downstream accepts
- x_idx, y_idx  out  IDX_W each  current pixel index
- x_offset, x_width, y_offset, y_width  out  64 each  latched viewport for scalers
- last_in_row  out  1  x_idx == H_RES-1, qualified by out_valid
- last_in_frame  out  1  last_in_row and y_idx == V_RES-1, qualified by out_valid
- busy  out  1  high in SCAN and DONE
- frame_done  out  1  one-cycle pulse after final pixel accepted

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: out_valid=0, busy=0. start=1 → latch all four cfg_* into the viewport registers, clear x/y to 0, go to SCAN.
- SCAN: out_valid=1. On transfer (out_valid && out_ready): if x<H_RES-1 then x+1; else x=0 and y+1. Transfer with last_in_frame → go to DONE, x/y hold the final value.
- DONE: out_valid=0, frame_done=1 for exactly this cycle, then IDLE.
- start is ignored in SCAN and DONE (no queuing). cfg_* changes while busy have no effect until the next latch.
- Handshake: out_valid never drops without a transfer; x_idx, y_idx, and the viewport outputs are stable while out_valid && !out_ready.
- Counters use unsigned compare against H_RES-1 / V_RES-1. There is no wrap beyond V_RES-1. The frame ends exactly at H_RES*V_RES transfers.
- Reset: all state registers go to IDLE; x_idx, y_idx = 0; viewport outputs = 64'h0; out_valid, busy, frame_done, last_* = 0. Reset asserted mid-frame abandons the frame with no frame_done pulse. Reset has priority over start in the same cycle.

## Timing
- start sampled high in IDLE at edge N → out_valid=1 with (0,0) and latched viewport visible after edge N.
- With out_ready held high: one pixel per cycle. Frame occupies H_RES*V_RES cycles of SCAN plus 1 cycle of DONE.
- Final transfer at edge M → frame_done high after edge M and low after edge M+1. busy falls after edge M+1.
- Earliest restart: start high during the cycle after DONE (IDLE). This gives a two-cycle gap between the last pixel and the next (0,0).
- last_in_row and last_in_frame are combinational from registered x/y/state; they add no latency.

## Configuration
- PIXEL_SCAN_CONTINUOUS_EN defined: DONE goes directly to SCAN instead of IDLE.
  - The viewport is re-latched from cfg_* on that transition.
  - x/y clear to 0, and out_valid reasserts the cycle after frame_done.
  - start is then only needed once after reset.
  - busy stays high continuously.
- Undefined: single-shot behaviour exactly as in Operation.

## Structure
- Shared package mandel_scan_pkg holds:
  - the state enum (IDLE, SCAN, DONE);
  - default resolution constants (640, 480);
  - the 64-bit double typedef shared with the scalers.
- One natural sub-module, scan_axis_counter, is instantiated twice:
  - inputs: step enable, clear, limit;
  - outputs: count and at_limit;
  - the x instance's wrap drives the y instance's step.

## Test plan
- H_RES=4, V_RES=3, out_ready=1, pulse start → 12 transfers in order (0,0),(1,0)…(3,2). last_in_row on x=3; last_in_frame only at (3,2). frame_done exactly one cycle later.
- Backpressure: out_ready low for 5 cycles at (2,1) → out_valid stays 1 and (2,1) is held. No skipped or duplicated pixel after release.
- cfg_x_offset changes from 2.0 (64'h4000000000000000) to -1.0 (64'hBFF0000000000000) mid-frame → x_offset stays 2.0 until the next start latch.
- start pulsed during SCAN and during DONE → ignored; exactly one frame is produced.
- Reset asserted at pixel (1,1) → the next cycle shows all outputs at reset values and no frame_done. A fresh start begins at (0,0).
- With PIXEL_SCAN_CONTINUOUS_EN: one start → two back-to-back frames. The second frame's (0,0) appears the cycle after frame_done, with the viewport re-latched.
